// File: rtl/lsu_hs_pkg.sv
// Shared types, address map constants and lane helpers for the lsu_hs load/store unit.
// Misalignment handling is selected in lsu_hs by LSU_MISALIGN_CHECK_EN.
package lsu_hs_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RESP
  } state_e;

  typedef enum logic [2:0] {
    SRC_DMEM,
    SRC_LEDR,
    SRC_LEDG,
    SRC_HEX,
    SRC_LCD,
    SRC_SW,
    SRC_NONE
  } src_e;

  localparam logic [31:0] IO_PAGE_MASK    = 32'hFFFF_F000;
  localparam logic [31:0] LEDR_BASE       = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE       = 32'h1000_1000;
  localparam logic [31:0] LCD_BASE        = 32'h1000_4000;
  localparam logic [31:0] SW_BASE         = 32'h1001_0000;
  localparam logic [31:0] HEX_BASE        = 32'h1000_2000;
  localparam logic [31:0] HEX_REGION_MASK = 32'hFFFF_E000;
  localparam logic [31:0] HEX_STRIDE      = 32'h0000_0400;
  localparam int unsigned HEX_STRIDE_LOG2 = $clog2(HEX_STRIDE);
  localparam int unsigned HEX_MAX         = 8;

  function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] bit_mask(logic [3:0] lanes);
    logic [31:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) m[8*b +: 8] = {8{lanes[b]}};
    return m;
  endfunction

  // Store data is right-aligned on the bus; replicate it so every lane the mask may select holds it.
  function automatic logic [31:0] lane_data(size_e sz, logic [31:0] wdata);
    case (sz)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_align(size_e sz, logic [1:0] off, logic uns,
                                             logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (sz)
      SZ_BYTE: return uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: return uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: return sh;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_sync.sv
// Byte-writable data RAM with one-cycle synchronous read.
module lsu_dmem_sync #(
  parameter int unsigned MEM_DEPTH      = 10,
  parameter string       DMEM_INIT_FILE = ""
) (
  input  logic                 i_clk,
  input  logic [3:0]           i_we,
  input  logic [MEM_DEPTH-3:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  localparam int unsigned WORDS = 2 ** (MEM_DEPTH - 2);

  logic [31:0] mem [WORDS];

  always_ff @(posedge i_clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_we[b]) mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/prim_register.sv
// Enable-gated register with synchronous active-high reset, shared by the IO registers.
module prim_register #(
  parameter int unsigned     WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_rst)     o_q <= RESET_VAL;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/lsu_hs.sv
// Load/store unit with valid/ready request and response channels, synchronous DMEM and MMIO.
// Define LSU_MISALIGN_CHECK_EN to report misaligned accesses as errors instead of aligning them down.
module lsu_hs
  import lsu_hs_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 10,
  parameter string       DMEM_INIT_FILE = "",
  parameter int unsigned NUM_HEX        = 8,
  parameter int unsigned SW_SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [31:0]          i_req_addr,
  input  logic [31:0]          i_req_wdata,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_we,
  input  logic                 i_req_unsigned,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [31:0]          o_rsp_rdata,
  output logic                 o_rsp_err,
  input  logic [31:0]          i_io_sw,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [7*NUM_HEX-1:0] o_io_hex
);

  state_e      state, state_nxt;
  size_e       req_size;
  src_e        req_src;
  logic [1:0]  req_off;
  logic [2:0]  req_hex_idx;
  logic        mis_err, req_err, accept, wr_en;
  logic [31:0] wr_lanes, wr_bits;
  logic [3:0]  wr_mask;

  size_e       size_q;
  src_e        src_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [2:0]  hex_idx_q;

  logic [31:0] dmem_rdata, rd_word, ld_data;
  logic [31:0] ledr_d, ledg_d, lcd_d;
  logic [6:0]  hex_q   [NUM_HEX];
  logic [6:0]  hex_pad [HEX_MAX];
  logic [31:0] sw_sync [SW_SYNC_STAGES];

  // Request decode, evaluated on the live request so stores can commit at the accept edge.
  always_comb begin
    req_size    = size_e'(i_req_size);
    req_hex_idx = 3'((i_req_addr - HEX_BASE) >> HEX_STRIDE_LOG2);
    req_src     = SRC_NONE;
    if ((i_req_addr >> MEM_DEPTH) == '0)                 req_src = SRC_DMEM;
    else if ((i_req_addr & IO_PAGE_MASK) == LEDR_BASE)   req_src = SRC_LEDR;
    else if ((i_req_addr & IO_PAGE_MASK) == LEDG_BASE)   req_src = SRC_LEDG;
    else if ((i_req_addr & IO_PAGE_MASK) == LCD_BASE)    req_src = SRC_LCD;
    else if ((i_req_addr & IO_PAGE_MASK) == SW_BASE)     req_src = SRC_SW;
    else if (((i_req_addr & HEX_REGION_MASK) == HEX_BASE) && (32'(req_hex_idx) < NUM_HEX))
      req_src = SRC_HEX;
`ifdef LSU_MISALIGN_CHECK_EN
    req_off = i_req_addr[1:0];
    mis_err = ((req_size == SZ_HALF) && req_off[0]) ||
              ((req_size == SZ_WORD) && (req_off != 2'b00));
`else
    mis_err = 1'b0;
    case (req_size)
      SZ_WORD: req_off = 2'b00;
      SZ_HALF: req_off = {i_req_addr[1], 1'b0};
      default: req_off = i_req_addr[1:0];
    endcase
`endif
    req_err = (req_size == SZ_RSVD) || (req_src == SRC_NONE) ||
              (i_req_we && (req_src == SRC_SW)) || mis_err;
  end

  always_comb begin
    accept   = i_req_valid && o_req_ready;
    wr_en    = accept && i_req_we && !req_err && !i_rst;
    wr_mask  = lane_mask(req_size, req_off);
    wr_bits  = bit_mask(wr_mask);
    wr_lanes = lane_data(req_size, i_req_wdata);
    ledr_d   = (o_io_ledr & ~wr_bits) | (wr_lanes & wr_bits);
    ledg_d   = (o_io_ledg & ~wr_bits) | (wr_lanes & wr_bits);
    lcd_d    = (o_io_lcd  & ~wr_bits) | (wr_lanes & wr_bits);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req_valid) state_nxt = i_req_we ? RESP : LOAD;
      LOAD:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (state == IDLE);
    o_rsp_valid = (state == RESP);
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      size_q    <= req_size;
      src_q     <= req_src;
      off_q     <= req_off;
      uns_q     <= i_req_unsigned;
      hex_idx_q <= req_hex_idx;
    end
  end

  lsu_dmem_sync #(
    .MEM_DEPTH      (MEM_DEPTH),
    .DMEM_INIT_FILE (DMEM_INIT_FILE)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_we    ((wr_en && (req_src == SRC_DMEM)) ? wr_mask : 4'b0000),
    .i_addr  (i_req_addr[MEM_DEPTH-1:2]),
    .i_wdata (wr_lanes),
    .o_rdata (dmem_rdata)
  );

  prim_register #(.WIDTH(32)) u_ledr (
    .i_clk (i_clk), .i_rst (i_rst), .i_en (wr_en && (req_src == SRC_LEDR)),
    .i_d   (ledr_d), .o_q (o_io_ledr)
  );

  prim_register #(.WIDTH(32)) u_ledg (
    .i_clk (i_clk), .i_rst (i_rst), .i_en (wr_en && (req_src == SRC_LEDG)),
    .i_d   (ledg_d), .o_q (o_io_ledg)
  );

  prim_register #(.WIDTH(32)) u_lcd (
    .i_clk (i_clk), .i_rst (i_rst), .i_en (wr_en && (req_src == SRC_LCD)),
    .i_d   (lcd_d), .o_q (o_io_lcd)
  );

  for (genvar n = 0; n < NUM_HEX; n++) begin : g_hex
    prim_register #(.WIDTH(7)) u_hex (
      .i_clk (i_clk), .i_rst (i_rst),
      .i_en  (wr_en && (req_src == SRC_HEX) && (req_hex_idx == 3'(n))),
      .i_d   (i_req_wdata[6:0]), .o_q (hex_q[n])
    );
    assign o_io_hex[7*n +: 7] = hex_q[n];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned s = 0; s < SW_SYNC_STAGES; s++) sw_sync[s] <= '0;
    end else begin
      sw_sync[0] <= i_io_sw;
      for (int unsigned s = 1; s < SW_SYNC_STAGES; s++) sw_sync[s] <= sw_sync[s-1];
    end
  end

  // Unpopulated HEX slots read as zero so the 3-bit index never leaves the array.
  always_comb begin
    for (int unsigned n = 0; n < HEX_MAX; n++) hex_pad[n] = '0;
    for (int unsigned n = 0; n < NUM_HEX; n++) hex_pad[n] = hex_q[n];
  end

  always_comb begin
    case (src_q)
      SRC_DMEM: rd_word = dmem_rdata;
      SRC_LEDR: rd_word = o_io_ledr;
      SRC_LEDG: rd_word = o_io_ledg;
      SRC_LCD:  rd_word = o_io_lcd;
      SRC_SW:   rd_word = sw_sync[SW_SYNC_STAGES-1];
      default:  rd_word = '0;
    endcase
    if (src_q == SRC_HEX) ld_data = {25'b0, hex_pad[hex_idx_q]};
    else                  ld_data = load_align(size_q, off_q, uns_q, rd_word);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else if (accept) begin
      o_rsp_rdata <= '0;
      o_rsp_err   <= req_err;
    end else if (state == LOAD) begin
      o_rsp_rdata <= o_rsp_err ? '0 : ld_data;
    end
  end

endmodule
